// File: rtl/round_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : round_controller_pkg
// Purpose : Shared definitions for the round controller and the HUD renderer:
//           controller state encodings, BCD score geometry and a helper that
//           maps a state to the ball-engine stop command.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package round_controller_pkg;

    localparam int          BCD_DIGIT_W = 4;
    localparam int          BCD_DIGITS  = 4;
    localparam logic [15:0] BCD_MAX     = 16'h9999;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_CLEAR = 3'd4,
        ST_OVER  = 3'd5
    } ctrl_state_e;

    // The ball engine may only run while serving or playing.
    function automatic logic stop_for_state(input ctrl_state_e s);
        return !((s == ST_SERVE) || (s == ST_PLAY));
    endfunction

endpackage
`default_nettype wire

// File: rtl/round_controller_bcd.sv
`default_nettype none
// ============================================================================
// Module  : bcd_counter4
// Purpose : Four-digit packed BCD up-counter, saturating at 9999.
// Ports   : clk   - clock
//           nRst  - asynchronous active-low reset (clears to 0000)
//           clr   - synchronous clear, wins over inc
//           inc   - add one (ignored at 9999)
//           value - packed BCD, most significant digit in [15:12]
// Revision: 1.0 - initial release
// ============================================================================
module bcd_counter4
    import round_controller_pkg::*;
(
    input  logic        clk,
    input  logic        nRst,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] value
);

    logic [15:0]           value_q;
    logic [15:0]           value_d;
    logic [BCD_DIGITS-1:0] carry;   // carry into each digit
    logic [BCD_DIGITS-1:0] wrap;    // digit currently holds 9

    assign carry[0] = 1'b1;

    // Ripple the +1 through the digits: a digit rolls 9->0 and passes the
    // carry on only when it receives one.
    generate
        for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
            assign wrap[g] = (value_q[g*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd9);
            assign value_d[g*BCD_DIGIT_W +: BCD_DIGIT_W] =
                !carry[g] ? value_q[g*BCD_DIGIT_W +: BCD_DIGIT_W] :
                wrap[g]   ? 4'd0 :
                            value_q[g*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1;
            if (g < BCD_DIGITS - 1) begin : g_carry
                assign carry[g+1] = carry[g] & wrap[g];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            value_q <= 16'h0000;
        end else if (clr) begin
            value_q <= 16'h0000;
        end else if (inc && (value_q != BCD_MAX)) begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule
`default_nettype wire

// File: rtl/round_controller.sv
`default_nettype none
// ============================================================================
// Module  : round_controller
// Purpose : Frame-paced game round sequencer for a breakout-style game:
//           start, serve, play, life-loss pause, level clear and game over.
// Ports   : clk, nRst              - clock, asynchronous active-low reset
//           frame_pulse            - one-cycle strobe per video frame
//           btn_action             - debounced action button level
//           game_state             - ball engine state (0=START, 1=PLAYING)
//           ball_out_of_bounds     - ball lost (valid on frame_pulse)
//           block_hit              - block collision (valid on frame_pulse)
//           action_out             - action request gated to SERVE
//           cmd_stop_game          - registered force-to-START command
//           blocks_reset           - one-cycle block map restore pulse
//           score                  - packed BCD score
//           lives, level           - remaining lives, 0-based level
//           ctrl_state             - current state encoding
// Revision: 1.0 - initial release
// ============================================================================
module round_controller
    import round_controller_pkg::*;
#(
    parameter int NUM_LIVES    = 3,
    parameter int NUM_BLOCKS   = 48,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        frame_pulse,
    input  logic        btn_action,
    input  logic        game_state,
    input  logic        ball_out_of_bounds,
    input  logic        block_hit,
    output logic        action_out,
    output logic        cmd_stop_game,
    output logic        blocks_reset,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic [2:0]  level,
    output logic [2:0]  ctrl_state
);

    localparam logic [1:0] LIVES_INIT  = 2'(NUM_LIVES);
    localparam logic [5:0] BLOCKS_INIT = 6'(NUM_BLOCKS);
    localparam logic [5:0] HOLD_LAST   = 6'(PAUSE_FRAMES - 1);
    localparam logic [5:0] HOLD_DONE   = 6'(PAUSE_FRAMES);

    ctrl_state_e state_q;
    logic [5:0]  frame_cnt_q;
    logic [1:0]  lives_q;
    logic [2:0]  level_q;
    logic [5:0]  blocks_left_q;
    logic        cmd_stop_q;
    logic        blocks_reset_q;

    logic        w_start;
    logic        w_score_inc;
    logic        w_last_hit;

    // New game: from IDLE at any time, from OVER only once the hold expired.
    assign w_start = frame_pulse && btn_action &&
                     ((state_q == ST_IDLE) ||
                      ((state_q == ST_OVER) && (frame_cnt_q == HOLD_DONE)));

    assign w_score_inc = frame_pulse && block_hit && (state_q == ST_PLAY);
    assign w_last_hit  = block_hit && (blocks_left_q == 6'd1);

    bcd_counter4 u_score (
        .clk   (clk),
        .nRst  (nRst),
        .clr   (w_start),
        .inc   (w_score_inc),
        .value (score)
    );

    // Every transition clears the frame counter and registers the stop
    // command of the destination state alongside the state itself.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q        <= ST_IDLE;
            frame_cnt_q    <= 6'd0;
            lives_q        <= 2'd0;
            level_q        <= 3'd0;
            blocks_left_q  <= 6'd0;
            cmd_stop_q     <= 1'b1;
            blocks_reset_q <= 1'b0;
        end else begin
            blocks_reset_q <= 1'b0;
            if (frame_pulse) begin
                if (w_start) begin
                    lives_q        <= LIVES_INIT;
                    level_q        <= 3'd0;
                    blocks_left_q  <= BLOCKS_INIT;
                    blocks_reset_q <= 1'b1;
                    state_q        <= ST_SERVE;
                    frame_cnt_q    <= 6'd0;
                    cmd_stop_q     <= stop_for_state(ST_SERVE);
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            // Waiting for the button; handled by w_start.
                        end
                        ST_SERVE: begin
                            if (game_state) begin
                                state_q     <= ST_PLAY;
                                frame_cnt_q <= 6'd0;
                                cmd_stop_q  <= stop_for_state(ST_PLAY);
                            end
                        end
                        ST_PLAY: begin
                            if (block_hit && (blocks_left_q != 6'd0)) begin
                                blocks_left_q <= blocks_left_q - 6'd1;
                            end
                            // Clearing the level takes priority over a lost
                            // ball in the same frame: no life is taken.
                            if (w_last_hit) begin
                                state_q     <= ST_CLEAR;
                                frame_cnt_q <= 6'd0;
                                cmd_stop_q  <= stop_for_state(ST_CLEAR);
                            end else if (ball_out_of_bounds) begin
                                lives_q     <= lives_q - 2'd1;
                                frame_cnt_q <= 6'd0;
                                if (lives_q == 2'd1) begin
                                    state_q    <= ST_OVER;
                                    cmd_stop_q <= stop_for_state(ST_OVER);
                                end else begin
                                    state_q    <= ST_PAUSE;
                                    cmd_stop_q <= stop_for_state(ST_PAUSE);
                                end
                            end
                        end
                        ST_PAUSE: begin
                            if (frame_cnt_q == HOLD_LAST) begin
                                state_q     <= ST_SERVE;
                                frame_cnt_q <= 6'd0;
                                cmd_stop_q  <= stop_for_state(ST_SERVE);
                            end else begin
                                frame_cnt_q <= frame_cnt_q + 6'd1;
                            end
                        end
                        ST_CLEAR: begin
                            if (frame_cnt_q == HOLD_LAST) begin
                                if (level_q != 3'd7) begin
                                    level_q <= level_q + 3'd1;
                                end
                                blocks_left_q  <= BLOCKS_INIT;
                                blocks_reset_q <= 1'b1;
                                state_q        <= ST_SERVE;
                                frame_cnt_q    <= 6'd0;
                                cmd_stop_q     <= stop_for_state(ST_SERVE);
                            end else begin
                                frame_cnt_q <= frame_cnt_q + 6'd1;
                            end
                        end
                        ST_OVER: begin
                            // Counter parks at HOLD_DONE, which arms w_start.
                            if (frame_cnt_q != HOLD_DONE) begin
                                frame_cnt_q <= frame_cnt_q + 6'd1;
                            end
                        end
                        default: begin
                            state_q     <= ST_IDLE;
                            frame_cnt_q <= 6'd0;
                            cmd_stop_q  <= stop_for_state(ST_IDLE);
                        end
                    endcase
                end
            end
        end
    end

    assign action_out    = (state_q == ST_SERVE) && btn_action;
    assign cmd_stop_game = cmd_stop_q;
    assign blocks_reset  = blocks_reset_q;
    assign lives         = lives_q;
    assign level         = level_q;
    assign ctrl_state    = state_q;

endmodule
`default_nettype wire

// File: doc/round_controller.md
ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 SHALL have parameter NUM_LIVES, default 3: lives granted at game start, range 1..3.
REQ-002 SHALL have parameter NUM_BLOCKS, default 48: blocks per level, range 1..63.
REQ-003 SHALL have parameter PAUSE_FRAMES, default 60: frames held in PAUSE, CLEAR and OVER, range 1..63.
REQ-004 SHALL have port clk, input, 1: system clock, single domain; all state changes on rising edge.
REQ-005 SHALL have port nRst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port frame_pulse, input, 1: one-cycle strobe per video frame.
REQ-007 SHALL have port btn_action, input, 1: debounced action button level.
REQ-008 SHALL have port game_state, input, 1: ball engine state, 0=START, 1=PLAYING.
REQ-009 SHALL have port ball_out_of_bounds, input, 1: ball lost, valid on frame_pulse.
REQ-010 SHALL have port block_hit, input, 1: latched block collision for the closing frame, valid on frame_pulse.
REQ-011 SHALL have port action_out, output, 1: gated action request to the ball engine.
REQ-012 SHALL have port cmd_stop_game, output, 1: forces the ball engine to START.
REQ-013 SHALL have port blocks_reset, output, 1: one-cycle pulse that restores the block map.
REQ-014 SHALL have port score, output, 16: four packed BCD digits, MSD in [15:12].
REQ-015 SHALL have port lives, output, 2: remaining lives.
REQ-016 SHALL have port level, output, 3: current level, 0-based.
REQ-017 SHALL have port ctrl_state, output, 3: current FSM state encoding, for HUD/debug.

Function
REQ-018 SHALL sample inputs and update state, counters and score only in cycles where frame_pulse=1, except where a requirement below states otherwise.
REQ-019 SHALL implement states IDLE=0, SERVE=1, PLAY=2, PAUSE=3, CLEAR=4, OVER=5; codes 6-7 SHALL return to IDLE on the next frame_pulse.
REQ-020 IDLE: on btn_action=1 SHALL load lives=NUM_LIVES, score=0, level=0, blocks_left=NUM_BLOCKS, pulse blocks_reset, and go to SERVE.
REQ-021 SERVE: action_out = btn_action, combinational, zero latency; in every other state action_out SHALL be 0.
REQ-022 SERVE: game_state=1 SHALL cause a transition to PLAY.
REQ-023 PLAY: block_hit=1 SHALL increment score by 1 in BCD with carry across digits, saturating at 9999.
REQ-024 PLAY: block_hit=1 SHALL also decrement blocks_left.
REQ-025 PLAY: block_hit=1 with blocks_left=1 SHALL go to CLEAR.
REQ-026 PLAY: ball_out_of_bounds=1 SHALL decrement lives; the next state SHALL be OVER if lives was 1, otherwise PAUSE.
REQ-027 PLAY: block_hit on the last block together with ball_out_of_bounds in the same frame SHALL go to CLEAR with no life lost.
REQ-028 PLAY: block_hit together with ball_out_of_bounds on a non-last block SHALL score the hit and also lose the life.
REQ-029 PAUSE: SHALL count PAUSE_FRAMES frame_pulses, then go to SERVE.
REQ-030 CLEAR: SHALL count PAUSE_FRAMES frame_pulses; on exit it SHALL increment level (saturating at 7), reload blocks_left, pulse blocks_reset, and go to SERVE.
REQ-031 OVER: SHALL ignore btn_action until PAUSE_FRAMES frames have elapsed; a later btn_action=1 SHALL perform the IDLE start action of REQ-020. Score SHALL hold until then.
REQ-032 The frame counter SHALL clear on every state entry and be 6 bits wide.
REQ-033 cmd_stop_game SHALL be registered and equal 1 in IDLE, PAUSE, CLEAR and OVER, and 0 in SERVE and PLAY. Because of this register, the ball engine advances one extra frame after PLAY exits.
REQ-034 blocks_reset SHALL be high for exactly one clk cycle: the cycle after the qualifying frame_pulse.

Reset
REQ-035 nRst=0 SHALL set state=IDLE, score=0, lives=0, level=0, blocks_left=0, counter=0, cmd_stop_game=1, blocks_reset=0, action_out=0.
REQ-036 A reset asserted mid-frame or mid-pause SHALL take effect immediately; no output pulse SHALL be emitted on release.

Structure
REQ-037 State encodings and the BCD digit width SHALL live in a shared package or header that the HUD renderer also includes.
REQ-038 The BCD score SHALL be a sub-module bcd_counter4 with inputs clk, nRst, clr, inc and output a 16-bit value, saturating at 9999.

Verification
REQ-039 Start: IDLE, btn_action=1 on a frame_pulse -> SERVE, lives=3, score=0x0000, one blocks_reset pulse, cmd_stop_game=0 the next cycle.
REQ-040 Scoring: in PLAY, 12 frames with block_hit=1 -> score=0x0012, blocks_left=36; a preload of 0x0999 plus one hit -> 0x1000; 0x9999 plus one hit -> 0x9999.
REQ-041 Life loss: lives=2, ball_out_of_bounds -> PAUSE, lives=1; after 60 frames -> SERVE; a further loss -> OVER, lives=0.
REQ-042 Level clear: blocks_left=1, with block_hit and ball_out_of_bounds in the same frame -> CLEAR, lives unchanged; after 60 frames level=1, blocks_left=48, one blocks_reset pulse.
REQ-043 OVER: btn_action held during the first 60 frames -> no effect; btn_action at frame 61 -> SERVE, score=0x0000, lives=3.
REQ-044 Reset: nRst dropped during CLEAR at frame 30 -> immediately IDLE with all outputs at their REQ-035 values.
